rr_grant_arb: RTL and testbench

//  Parametrised round-robin arbiter with registered grant and valid/ready

---
 rtl/rr_grant_arb_if.sv | 24 ++
 rtl/rr_grant_arb.sv | 157 +++++++++++++++
 tb/tb_rr_grant_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_arb_if.sv
// Request/grant bundle between per-channel request queues (master) and the
// round-robin arbiter (slave).
interface rr_grant_arb_if #(
  parameter int unsigned LG_N = 2
);
  localparam int unsigned N = 1 << LG_N;

  logic [N-1:0]    req;
  logic [N-1:0]    req_last;
  logic            gnt_ready;
  logic            gnt_valid;
  logic [LG_N-1:0] gnt_idx;
  logic [N-1:0]    gnt_onehot;

  modport master (
    output req, req_last, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot
  );

  modport slave (
    input  req, req_last, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot
  );
endinterface

// File: rtl/rr_grant_arb.sv
// Round-robin arbiter with a registered grant held until accepted.
// Define RR_GRANT_ARB_BURST_EN to enable multi-beat locked bursts (req_last, MAX_BURST).
module rr_grant_arb #(
  parameter int unsigned LG_N      = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  rr_grant_arb_if.slave bus
);
  localparam int unsigned N = 1 << LG_N;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StLockWait,
    StLockGrant
  } state_e;

  state_e          state_q, state_d;
  logic [LG_N-1:0] gnt_idx_q, gnt_idx_d;
  logic [LG_N-1:0] r_ptr_q, r_ptr_d;

  logic            gnt_valid;
  logic            accept;
  logic            slot_free;
  logic            any_req;
  logic [LG_N-1:0] arb_ptr;
  logic [LG_N-1:0] winner;
  logic [LG_N-1:0] idx_inc;

  // Lowest set bit of req after rotating so that bit ptr lands at position 0.
  function automatic logic [LG_N-1:0] rr_pick(input logic [N-1:0] r, input logic [LG_N-1:0] p);
    logic [N-1:0]    rot;
    logic [LG_N-1:0] pick;
    rot  = N'({r, r} >> p);
    pick = p;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pick = p + LG_N'(i);
    end
    return pick;
  endfunction

  assign gnt_valid = (state_q == StGrant) || (state_q == StLockGrant);
  assign accept    = gnt_valid & bus.gnt_ready;
  assign slot_free = ~gnt_valid | accept;
  assign any_req   = |bus.req;
  assign idx_inc   = gnt_idx_q + LG_N'(1);
  assign arb_ptr   = accept ? idx_inc : r_ptr_q;
  assign winner    = rr_pick(bus.req, arb_ptr);

`ifdef RR_GRANT_ARB_BURST_EN
  localparam int unsigned BeatW = $clog2(MAX_BURST) + 1;
  localparam logic [BeatW-1:0] MaxBeat = BeatW'(MAX_BURST);

  logic [BeatW-1:0] beat_q, beat_d;
  logic [BeatW-1:0] beat_nxt;
  logic             locked;
  logic             release_lock;
  logic             req_locked;

  assign locked       = (state_q == StLockWait) || (state_q == StLockGrant);
  assign beat_nxt     = locked ? beat_q + BeatW'(1) : BeatW'(1);
  assign release_lock = bus.req_last[gnt_idx_q] || (beat_nxt >= MaxBeat);
  assign req_locked   = bus.req[gnt_idx_q];

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    r_ptr_d   = r_ptr_q;
    beat_d    = beat_q;
    unique case (state_q)
      StIdle, StGrant: begin
        if (accept && !release_lock) begin
          // First beat of a burst: stay on this channel, pointer frozen.
          beat_d  = beat_nxt;
          state_d = req_locked ? StLockGrant : StLockWait;
        end else if (slot_free) begin
          if (accept) r_ptr_d = idx_inc;
          if (any_req) begin
            state_d   = StGrant;
            gnt_idx_d = winner;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLockWait: begin
        if (req_locked) state_d = StLockGrant;
      end
      StLockGrant: begin
        if (accept) begin
          if (release_lock) begin
            beat_d  = '0;
            r_ptr_d = idx_inc;
            if (any_req) begin
              state_d   = StGrant;
              gnt_idx_d = winner;
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_d  = beat_nxt;
            state_d = req_locked ? StLockGrant : StLockWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^bus.req_last;

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    r_ptr_d   = r_ptr_q;
    if (accept) r_ptr_d = idx_inc;
    if (slot_free) begin
      if (any_req) begin
        state_d   = StGrant;
        gnt_idx_d = winner;
      end else begin
        state_d = StIdle;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      r_ptr_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      r_ptr_q   <= r_ptr_d;
    end
  end

  always_comb begin
    bus.gnt_valid  = gnt_valid;
    bus.gnt_idx    = gnt_idx_q;
    bus.gnt_onehot = '0;
    if (gnt_valid) bus.gnt_onehot[gnt_idx_q] = 1'b1;
  end
endmodule

// File: tb/tb_rr_grant_arb.sv
// Randomised and directed bench for rr_grant_arb (N=4, MAX_BURST=4) against a
// behavioural model; honours RR_GRANT_ARB_BURST_EN like the design.
module tb_rr_grant_arb;
  localparam int unsigned LG_N      = 2;
  localparam int unsigned N         = 4;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_grant_arb_if #(.LG_N(LG_N)) bus ();

  rr_grant_arb #(.LG_N(LG_N), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: current grant, pointer, burst lock.
  int m_valid, m_idx, m_ptr, m_lock, m_beats;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0; m_lock = 0; m_beats = 0;
  endtask

  task automatic arbitrate(input logic [N-1:0] r, input int p);
    m_valid = 0;
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) begin
        m_valid = 1;
        m_idx   = (p + k) % N;
        break;
      end
    end
  endtask

  task automatic model_update(input logic [N-1:0] r, input logic [N-1:0] rl, input logic rdy);
    int acc;
    acc = m_valid && rdy;
`ifdef RR_GRANT_ARB_BURST_EN
    if (acc) begin
      m_beats = m_lock ? m_beats + 1 : 1;
      if (rl[m_idx] || m_beats >= MAX_BURST) begin
        m_lock  = 0;
        m_beats = 0;
        m_ptr   = (m_idx + 1) % N;
        arbitrate(r, m_ptr);
      end else begin
        m_lock  = 1;
        m_valid = r[m_idx] ? 1 : 0;
      end
    end else if (!m_valid) begin
      if (m_lock) m_valid = r[m_idx] ? 1 : 0;
      else arbitrate(r, m_ptr);
    end
`else
    if (acc) m_ptr = (m_idx + 1) % N;
    if (!m_valid || acc) arbitrate(r, m_ptr);
`endif
  endtask

  task automatic check_model();
    logic [N-1:0] oh;
    oh = '0;
    if (m_valid != 0) oh[m_idx] = 1'b1;
    check("valid", bus.gnt_valid, m_valid);
    check("idx", bus.gnt_idx, m_idx);
    check("onehot", bus.gnt_onehot, oh);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] rl, input logic rdy);
    bus.req       = r;
    bus.req_last  = rl;
    bus.gnt_ready = rdy;
    @(posedge clk);
    model_update(r, rl, rdy);
    #1;
    check_model();
  endtask

  // Asynchronous reset pulse launched between clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", bus.gnt_valid, 0);
    check("rst_idx", bus.gnt_idx, 0);
    check("rst_onehot", bus.gnt_onehot, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.req_last = '0; bus.gnt_ready = 1'b0;
    model_reset();
    do_reset();

    // Reset mid-grant, then pointer restarts at 0.
    step(4'b0100, 4'b0000, 1'b0);
    check("t1_pre_idx", bus.gnt_idx, 2);
    do_reset();
    step(4'b1111, 4'b1111, 1'b1);
    check("t1_post_idx", bus.gnt_idx, 0);

    // Strict rotation with everyone requesting.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'b1111, 1'b1);
      check("t2_rot", bus.gnt_idx, i % 4);
    end

    // Grant held while not ready, even after req drops.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0101, 4'b1111, 1'b0);
      check("t3_hold", bus.gnt_idx, 0);
    end
    step(4'b0000, 4'b1111, 1'b0);
    check("t3_noretract", bus.gnt_valid, 1);
    step(4'b0000, 4'b1111, 1'b1);
    check("t3_drain", bus.gnt_valid, 0);

    // Single requester at the top index, then pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4'b1000, 4'b1111, 1'b1);
      check("t4_only3", bus.gnt_idx, 3);
    end
    step(4'b1010, 4'b1111, 1'b1);
    check("t4_wrap1", bus.gnt_idx, 1);
    step(4'b1010, 4'b1111, 1'b1);
    check("t4_then3", bus.gnt_idx, 3);

`ifdef RR_GRANT_ARB_BURST_EN
    // Burst capped at MAX_BURST beats, then forced release.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 4'b0000, 1'b1);
      check("t5_cap", bus.gnt_idx, (i < 4) ? 0 : 1);
    end
    // Burst ended early by req_last on beat 2.
    do_reset();
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b1);
    check("t5_b1", bus.gnt_idx, 0);
    step(4'b0011, 4'b0001, 1'b1);
    check("t5_last", bus.gnt_idx, 1);
    // Locked channel drops req: nobody else gets in.
    do_reset();
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 4'b0000, 1'b1);
      check("t6_gap", bus.gnt_valid, 0);
    end
    step(4'b0011, 4'b0000, 1'b1);
    check("t6_resume_v", bus.gnt_valid, 1);
    check("t6_resume_i", bus.gnt_idx, 0);
`endif

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 7));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
